// File: rtl/apb_cmd_master_if.sv
// apb_cmd_master_if: command stream, response stream and APB requester bus.
// The master modport is the apb_cmd_master side; the slave modport is the
// environment side (command source, response sink and APB completer).
interface apb_cmd_master_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned STRB_W = DATA_W / 8;

  // Command stream
  logic              iCMD_VALID;
  logic              oCMD_READY;
  logic              iCMD_WRITE;
  logic [ADDR_W-1:0] iCMD_ADDR;
  logic [DATA_W-1:0] iCMD_WDATA;
  logic [STRB_W-1:0] iCMD_STRB;

  // Response stream
  logic              oRSP_VALID;
  logic              iRSP_READY;
  logic [DATA_W-1:0] oRSP_RDATA;
  logic              oRSP_ERR;

  // APB bus
  logic              oPSEL;
  logic              oPENABLE;
  logic              oPWRITE;
  logic [ADDR_W-1:0] oPADDR;
  logic [DATA_W-1:0] oPWDATA;
  logic [STRB_W-1:0] oPSTRB;
  logic [DATA_W-1:0] iPRDATA;
  logic              iPREADY;
  logic              iPSLVERR;

  modport master (
    input  iCMD_VALID, iCMD_WRITE, iCMD_ADDR, iCMD_WDATA, iCMD_STRB,
    output oCMD_READY,
    output oRSP_VALID, oRSP_RDATA, oRSP_ERR,
    input  iRSP_READY,
    output oPSEL, oPENABLE, oPWRITE, oPADDR, oPWDATA, oPSTRB,
    input  iPRDATA, iPREADY, iPSLVERR
  );

  modport slave (
    output iCMD_VALID, iCMD_WRITE, iCMD_ADDR, iCMD_WDATA, iCMD_STRB,
    input  oCMD_READY,
    input  oRSP_VALID, oRSP_RDATA, oRSP_ERR,
    output iRSP_READY,
    input  oPSEL, oPENABLE, oPWRITE, oPADDR, oPWDATA, oPSTRB,
    output iPRDATA, iPREADY, iPSLVERR
  );
endinterface

// File: rtl/apb_cmd_master.sv
// apb_cmd_master: turns a valid/ready command stream into single APB3/APB4
// transfers (SETUP -> ACCESS) and returns one response per transfer.
// One transfer outstanding; wait states via iPREADY; iPSLVERR returned.
// Optional: define APB_TIMEOUT_EN to force completion with an error after
// TIMEOUT consecutive ACCESS cycles with iPREADY low.
module apb_cmd_master #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input logic              iPCLK,
  input logic              iPRESET,
  apb_cmd_master_if.master bus
);
  localparam int unsigned STRB_W = DATA_W / 8;

  if ((TIMEOUT < 2) || (TIMEOUT > 255)) begin : g_bad_timeout
    $error("apb_cmd_master: TIMEOUT must be in 2..255");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t            r_state;
  logic              r_cmd_ready;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_err;
  logic              r_psel;
  logic              r_penable;
  logic              r_pwrite;
  logic [ADDR_W-1:0] r_paddr;
  logic [DATA_W-1:0] r_pwdata;
  logic [STRB_W-1:0] r_pstrb;
  logic              w_accept;

`ifdef APB_TIMEOUT_EN
  localparam logic [7:0] LP_WAIT_LAST = 8'(TIMEOUT - 1);
  logic [7:0] r_wait;
  logic       w_timeout;
  // r_wait counts completed low-iPREADY ACCESS cycles, so the TIMEOUT-th one
  // ends on the edge where r_wait already holds TIMEOUT-1.
  assign w_timeout = (r_wait == LP_WAIT_LAST);
`endif

  assign w_accept = (r_state == S_IDLE) && r_cmd_ready && bus.iCMD_VALID;

  assign bus.oCMD_READY = r_cmd_ready;
  assign bus.oRSP_VALID = r_rsp_valid;
  assign bus.oRSP_RDATA = r_rsp_rdata;
  assign bus.oRSP_ERR   = r_rsp_err;
  assign bus.oPSEL      = r_psel;
  assign bus.oPENABLE   = r_penable;
  assign bus.oPWRITE    = r_pwrite;
  assign bus.oPADDR     = r_paddr;
  assign bus.oPWDATA    = r_pwdata;
  assign bus.oPSTRB     = r_pstrb;

  // Transfer sequencer IDLE -> SETUP -> ACCESS -> RESP with registered outputs.
  always_ff @(posedge iPCLK or posedge iPRESET) begin
    if (iPRESET) begin
      r_state     <= S_IDLE;
      r_cmd_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_pstrb     <= '0;
`ifdef APB_TIMEOUT_EN
      r_wait      <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_cmd_ready <= 1'b0;
            r_psel      <= 1'b1;
            r_penable   <= 1'b0;
            r_pwrite    <= bus.iCMD_WRITE;
            r_paddr     <= bus.iCMD_ADDR;
            r_pwdata    <= bus.iCMD_WDATA;
            r_pstrb     <= bus.iCMD_WRITE ? bus.iCMD_STRB : '0;
            r_state     <= S_SETUP;
`ifdef APB_TIMEOUT_EN
            r_wait      <= '0;
`endif
          end else begin
            r_cmd_ready <= 1'b1;
          end
        end

        S_SETUP: begin
          r_penable <= 1'b1;
          r_state   <= S_ACCESS;
        end

        S_ACCESS: begin
          if (bus.iPREADY) begin
            r_rsp_rdata <= r_pwrite ? '0 : bus.iPRDATA;
            r_rsp_err   <= bus.iPSLVERR;
            r_rsp_valid <= 1'b1;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_state     <= S_RESP;
          end
`ifdef APB_TIMEOUT_EN
          else if (w_timeout) begin
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_state     <= S_RESP;
          end else begin
            r_wait <= r_wait + 8'd1;
          end
`endif
        end

        S_RESP: begin
          // Raising ready on the handshake edge keeps the loop at 4 cycles.
          if (bus.iRSP_READY) begin
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_apb_cmd_master.sv
// tb_apb_cmd_master: directed stimulus for apb_cmd_master with a scoreboard.
// Stimulus pushes the expected response and APB shape of each command; a
// monitor tracks the APB bus and pops/compares on every response handshake.
module tb_apb_cmd_master;
  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned TIMEOUT = 16;

  typedef struct {
    logic        write;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          acc;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clk;
  logic rst;

  apb_cmd_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  apb_cmd_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .iPCLK  (clk),
    .iPRESET(rst),
    .bus    (bus)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  exp_t        exp_q[$];
  int          sl_waits  = 0;
  logic [31:0] sl_prdata = '0;
  logic        sl_slverr = 1'b0;
  int          last_accept_cyc = 0;
  int          last_hs_cyc     = 0;
  int          rsp_rise_cyc    = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edge counter used for latency measurements.
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, want);
  endtask

  // APB completer: iPREADY rises after sl_waits wait states. During wait
  // states it drives junk data and PSLVERR=1, which the master must ignore.
  initial begin : slave
    int acc_cnt;
    acc_cnt       = 0;
    bus.iPREADY   = 1'b0;
    bus.iPRDATA   = '0;
    bus.iPSLVERR  = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.oPSEL && bus.oPENABLE) begin
        if (acc_cnt >= sl_waits) begin
          bus.iPREADY  = 1'b1;
          bus.iPRDATA  = sl_prdata;
          bus.iPSLVERR = sl_slverr;
        end else begin
          bus.iPREADY  = 1'b0;
          bus.iPRDATA  = 32'hDEAD_BEEF;
          bus.iPSLVERR = 1'b1;
        end
        acc_cnt++;
      end else begin
        acc_cnt      = 0;
        bus.iPREADY  = 1'b0;
        bus.iPRDATA  = 32'hDEAD_BEEF;
        bus.iPSLVERR = 1'b1;
      end
    end
  end

  // Monitor: records each APB transfer's shape and checks responses.
  initial begin : monitor
    bit          in_xfer, prev_rv, stable, d_stable;
    int          n_set, n_acc, d_set, d_acc;
    logic [15:0] c_addr, d_addr;
    logic        c_write, d_write;
    logic [31:0] c_wdata, d_wdata;
    logic [3:0]  c_strb, d_strb;
    exp_t        e;
    in_xfer = 0; prev_rv = 0; stable = 1; d_stable = 1;
    n_set = 0; n_acc = 0; d_set = 0; d_acc = 0;
    c_addr = '0; c_write = 0; c_wdata = '0; c_strb = '0;
    d_addr = '0; d_write = 0; d_wdata = '0; d_strb = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_xfer = 0;
        prev_rv = 0;
      end else begin
        if (bus.iCMD_VALID && bus.oCMD_READY) last_accept_cyc = cyc + 1;
        if (bus.oPSEL) begin
          if (!in_xfer) begin
            in_xfer = 1; n_set = 0; n_acc = 0; stable = 1;
            c_addr = bus.oPADDR; c_write = bus.oPWRITE;
            c_wdata = bus.oPWDATA; c_strb = bus.oPSTRB;
          end else if (bus.oPADDR !== c_addr || bus.oPWRITE !== c_write ||
                       bus.oPWDATA !== c_wdata || bus.oPSTRB !== c_strb) begin
            stable = 0;
          end
          if (bus.oPENABLE) n_acc++;
          else n_set++;
        end else if (in_xfer) begin
          in_xfer = 0;
          d_set = n_set; d_acc = n_acc; d_stable = stable;
          d_addr = c_addr; d_write = c_write; d_wdata = c_wdata; d_strb = c_strb;
        end
        if (bus.oRSP_VALID && !prev_rv) rsp_rise_cyc = cyc;
        prev_rv = bus.oRSP_VALID;
        if (bus.oRSP_VALID && bus.iRSP_READY) begin
          last_hs_cyc = cyc + 1;
          if (exp_q.size() == 0) begin
            chk("rsp_unexpected", 32'(exp_q.size()), 32'd1);
          end else begin
            e = exp_q.pop_front();
            chk("rsp_rdata", bus.oRSP_RDATA, e.rdata);
            chk("rsp_err", 32'(bus.oRSP_ERR), 32'(e.err));
            chk("setup_cycles", 32'(d_set), 32'd1);
            chk("access_cycles", 32'(d_acc), 32'(e.acc));
            chk("apb_stable", 32'(d_stable), 32'd1);
            chk("paddr", 32'(d_addr), 32'(e.addr));
            chk("pwrite", 32'(d_write), 32'(e.write));
            chk("pstrb", 32'(d_strb), 32'(e.strb));
            if (e.write) chk("pwdata", d_wdata, e.wdata);
            chk("rsp_latency", 32'(rsp_rise_cyc - last_accept_cyc), 32'(1 + e.acc));
          end
        end
      end
    end
  end

  // Issue one command; optionally queue its expected response.
  task automatic do_cmd(input logic w, input logic [15:0] a, input logic [31:0] d,
                        input logic [3:0] s, input int waits, input logic [31:0] prd,
                        input logic serr, input logic [31:0] xr, input logic xe,
                        input int xacc, input bit push);
    exp_t e;
    bit   got;
    sl_waits = waits; sl_prdata = prd; sl_slverr = serr;
    if (push) begin
      e.write = w; e.addr = a; e.wdata = d; e.strb = w ? s : 4'h0;
      e.acc = xacc; e.rdata = xr; e.err = xe;
      exp_q.push_back(e);
    end
    bus.iCMD_WRITE = w; bus.iCMD_ADDR = a; bus.iCMD_WDATA = d; bus.iCMD_STRB = s;
    bus.iCMD_VALID = 1'b1;
    got = 0;
    for (int t = 0; t < 200 && !got; t++) begin
      @(negedge clk);
      if (bus.oCMD_READY) got = 1;
    end
    chk("cmd_accept", 32'(got), 32'd1);
    @(posedge clk); #1;
    // Junk on the command inputs after acceptance must not reach the bus.
    bus.iCMD_VALID = 1'b0;
    bus.iCMD_WRITE = ~w; bus.iCMD_ADDR = 16'hBEEF;
    bus.iCMD_WDATA = 32'hA5A5_A5A5; bus.iCMD_STRB = 4'h6;
  endtask

  task automatic wait_done();
    bit ok = 0;
    for (int t = 0; t < 400 && !ok; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !bus.oRSP_VALID) ok = 1;
    end
    chk("rsp_drain", 32'(ok), 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin : stim
    exp_t eb;
    bit   got;
    rst = 1'b1;
    bus.iCMD_VALID = 1'b0; bus.iCMD_WRITE = 1'b0; bus.iCMD_ADDR = '0;
    bus.iCMD_WDATA = '0;   bus.iCMD_STRB = '0;    bus.iRSP_READY = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cmd_ready", 32'(bus.oCMD_READY), 32'd0);
    chk("rst_psel", 32'(bus.oPSEL), 32'd0);
    chk("rst_penable", 32'(bus.oPENABLE), 32'd0);
    chk("rst_rsp_valid", 32'(bus.oRSP_VALID), 32'd0);
    chk("rst_outputs", {bus.oRSP_RDATA ^ bus.oPWDATA}, 32'd0);
    chk("rst_bus", {15'd0, bus.oRSP_ERR, bus.oPADDR}, 32'd0);
    chk("rst_strb_write", {27'd0, bus.oPWRITE, bus.oPSTRB}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_reset", 32'(bus.oCMD_READY), 32'd1);

    // Zero-wait write; slave data must not leak into a write response.
    do_cmd(1'b1, 16'h0000, 32'h1234_5678, 4'hF, 0, 32'hCAFE_F00D, 1'b0,
           32'h0, 1'b0, 1, 1'b1);
    wait_done();
    // Read with 3 wait states, strobes forced to zero.
    do_cmd(1'b0, 16'h0000, 32'h0, 4'hF, 3, 32'h1234_5678, 1'b0,
           32'h1234_5678, 1'b0, 4, 1'b1);
    wait_done();
    // Write with slave error, then a clean read.
    do_cmd(1'b1, 16'h0ABC, 32'h0F0F_0F0F, 4'b0101, 0, 32'h7777_7777, 1'b1,
           32'h0, 1'b1, 1, 1'b1);
    wait_done();
    do_cmd(1'b0, 16'h0010, 32'h0, 4'h0, 2, 32'h0BAD_F00D, 1'b0,
           32'h0BAD_F00D, 1'b0, 3, 1'b1);
    wait_done();

    // Response backpressure with the next command already waiting.
    bus.iRSP_READY = 1'b0;
    do_cmd(1'b0, 16'h0020, 32'h0, 4'h3, 1, 32'h1111_2222, 1'b0,
           32'h1111_2222, 1'b0, 2, 1'b1);
    eb = '{write: 1'b1, addr: 16'h0024, wdata: 32'h3333_4444, strb: 4'hC,
           acc: 1, rdata: 32'h0, err: 1'b0};
    exp_q.push_back(eb);
    bus.iCMD_WRITE = 1'b1; bus.iCMD_ADDR = 16'h0024;
    bus.iCMD_WDATA = 32'h3333_4444; bus.iCMD_STRB = 4'hC; bus.iCMD_VALID = 1'b1;
    got = 0;
    for (int t = 0; t < 50 && !got; t++) begin
      @(negedge clk);
      if (bus.oRSP_VALID) got = 1;
    end
    chk("bp_rsp_seen", 32'(got), 32'd1);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      chk("bp_cmd_ready", 32'(bus.oCMD_READY), 32'd0);
      chk("bp_rsp_valid", 32'(bus.oRSP_VALID), 32'd1);
      chk("bp_rsp_rdata", bus.oRSP_RDATA, 32'h1111_2222);
      chk("bp_rsp_err", 32'(bus.oRSP_ERR), 32'd0);
    end
    sl_waits = 0; sl_prdata = 32'h9999_8888; sl_slverr = 1'b0;
    @(posedge clk); #1;
    bus.iRSP_READY = 1'b1;
    got = 0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      if (bus.oCMD_READY) got = 1;
    end
    chk("bp_accept_seen", 32'(got), 32'd1);
    @(posedge clk); #1;
    bus.iCMD_VALID = 1'b0;
    chk("bp_accept_after_hs", 32'(last_accept_cyc - last_hs_cyc), 32'd1);
    wait_done();

    // Asynchronous reset during an ACCESS wait state drops the transfer.
    do_cmd(1'b0, 16'h0030, 32'h0, 4'h0, 10, 32'h4444_4444, 1'b0,
           32'h0, 1'b0, 11, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid_in_access", {30'd0, bus.oPSEL, bus.oPENABLE}, 32'd3);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_psel", 32'(bus.oPSEL), 32'd0);
    chk("rst_mid_penable", 32'(bus.oPENABLE), 32'd0);
    chk("rst_mid_rsp_valid", 32'(bus.oRSP_VALID), 32'd0);
    chk("rst_mid_paddr", 32'(bus.oPADDR), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_ready_first_edge", 32'(bus.oCMD_READY), 32'd1);

    // A transfer after the aborted one still works.
    do_cmd(1'b0, 16'h0034, 32'h0, 4'h0, 0, 32'h5A5A_0001, 1'b0,
           32'h5A5A_0001, 1'b0, 1, 1'b1);
    wait_done();

`ifdef APB_TIMEOUT_EN
    // iPREADY never rises: forced completion after TIMEOUT ACCESS cycles.
    do_cmd(1'b0, 16'h0040, 32'h0, 4'h0, 1000, 32'h6666_6666, 1'b0,
           32'h0, 1'b1, 16, 1'b1);
    wait_done();
    // iPREADY on the 16th ACCESS cycle wins over the timeout.
    do_cmd(1'b0, 16'h0044, 32'h0, 4'h0, 15, 32'h55AA_55AA, 1'b0,
           32'h55AA_55AA, 1'b0, 16, 1'b1);
    wait_done();
    do_cmd(1'b1, 16'h0048, 32'h0102_0304, 4'h9, 15, 32'h0, 1'b1,
           32'h0, 1'b1, 16, 1'b1);
    wait_done();
`endif

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
